wb_sequencer: RTL and testbench
===============================

Name: wb_sequencer

Overview:
- Multicycle write-back controller that sequences the register-file write-back source mux (9-way, 4-bit select) and the register-file write strobe.
- Accepts one write-back request at a time from the main control FSM.
- Waits the required memory or mult/div latency, then drives the mux select and a single-cycle reg_write.
- Reports completion or error back to the main control FSM.

Parameters:
- MEM_LAT, 2, cycles between request acceptance and valid memory-data-register contents for loads (1..7).
- MD_TIMEOUT, 40, maximum cycles to wait for md_done on HI/LO sources before flagging an error (1..63).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- wb_req  input  1  write-back request from main control; sampled only in IDLE
- wb_src  input  4  source code; equals the mux select value
- wb_rd  input  5  destination register number
- md_done  input  1  mult/div unit result valid (level)
- mem_to_reg  output  4  write-back mux select
- reg_write  output  1  register-file write enable
- reg_wr_addr  output  5  register-file write address
- mdr_load  output  1  load strobe for the memory data register
- busy  output  1  high in every state except IDLE
- wb_done  output  1  one-cycle completion pulse
- wb_err  output  1  one-cycle error pulse

Behaviour:
- Source encoding:
  - 0 = ALUOut
  - 1 = load data
  - 2 = constant 227 (exception vector)
  - 3 = HI
  - 4 = LO
  - 5 = shifter output
  - 6 = SLT flag
  - 8 = LUI value
  - 7 and 9..15 are illegal.
- Reset, and any cycle with reset=1:
  - state=IDLE; all counters cleared.
  - mem_to_reg=0, reg_wr_addr=0, reg_write=0, mdr_load=0, busy=0, wb_done=0, wb_err=0.
  - Reset mid-operation aborts with no write, no done, no err.
- States: IDLE, MEM_WAIT, MD_WAIT, WRITE, FINISH, ERROR.
- IDLE:
  - On wb_req=1, latch wb_src and wb_rd into internal registers; later changes on the inputs are ignored.
  - src 1 -> MEM_WAIT, with the latency counter loaded to MEM_LAT-1.
  - src 3 or 4 -> MD_WAIT, with the timeout counter cleared.
  - src 0,2,5,6,8 -> WRITE.
  - illegal src -> ERROR.
- MEM_WAIT:
  - Counter decrements each cycle.
  - mdr_load=1 in the cycle the counter is 0, then -> WRITE.
  - Total of MEM_LAT cycles spent in MEM_WAIT.
- MD_WAIT:
  - If md_done=1 -> WRITE, including when md_done is already high on the first MD_WAIT cycle.
  - Else the counter increments; when it reaches MD_TIMEOUT-1 without md_done -> ERROR.
- WRITE (exactly one cycle):
  - mem_to_reg = latched src; reg_wr_addr = latched rd.
  - reg_write=1 unless latched rd==0; a write to $0 is suppressed but is still treated as success.
  - -> FINISH.
- FINISH:
  - wb_done=1 for one cycle; mem_to_reg and reg_wr_addr hold their WRITE values.
  - -> IDLE.
- ERROR:
  - wb_err=1 for one cycle; reg_write stays 0; mem_to_reg is forced to 0.
  - -> IDLE.
- mem_to_reg holds the latched src from acceptance through FINISH, so the mux output settles before the write edge; it is 0 in IDLE.
- All outputs are registered or derived from state only; no combinational path from any input to any output.
- Latency from wb_req accepted (edge N) to reg_write high:
  - src 0/2/5/6/8: cycle N+1.
  - load: N+1+MEM_LAT.
  - HI/LO: edge after md_done is seen.
  - wb_done always follows reg_write by one cycle.
- A wb_req asserted while busy is ignored; the requester must hold wb_req until it sees wb_done or wb_err. wb_req still high in the IDLE cycle after FINISH is accepted as a new request.

Test Plan:
- Reset then wb_req with src=0, rd=8 -> reg_write=1 one cycle after acceptance with mem_to_reg=0 and reg_wr_addr=8; wb_done on the next cycle; busy for 2 cycles.
- src=1, rd=9, MEM_LAT=2 -> mdr_load on the 2nd MEM_WAIT cycle; reg_write 3 cycles after acceptance with mem_to_reg=1; then wb_done.
- src=4, rd=10, md_done raised 5 cycles later -> reg_write with mem_to_reg=4 the cycle after md_done; with md_done never raised and MD_TIMEOUT=40 -> wb_err after 40 MD_WAIT cycles and no reg_write.
- src=7 and src=12 -> wb_err one cycle after acceptance, no reg_write; src=2, rd=0 -> no reg_write but wb_done pulses.
- Assert reset during MEM_WAIT of a load -> next cycle IDLE, all outputs 0, no reg_write, no wb_done; a subsequent src=8 request completes normally.
- wb_req held high continuously with src=6 -> back-to-back writes every 3 cycles (accept, WRITE, FINISH); src/rd changes applied while busy do not affect the transaction in flight.

Source files
------------

// File: rtl/wb_sequencer.sv
// wb_sequencer: multicycle register-file write-back controller with memory/mult-div wait and error reporting
module wb_sequencer #(
  parameter int MEM_LAT    = 2,
  parameter int MD_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_req,
  input  logic [3:0] wb_src,
  input  logic [4:0] wb_rd,
  input  logic       md_done,
  output logic [3:0] mem_to_reg,
  output logic       reg_write,
  output logic [4:0] reg_wr_addr,
  output logic       mdr_load,
  output logic       busy,
  output logic       wb_done,
  output logic       wb_err
);
  typedef enum logic [2:0] {IDLE, MEM_WAIT, MD_WAIT, WRITE, FINISH, ERROR} state_t;
  state_t     state_q, state_d;
  logic [3:0] src_q, src_d, mem_to_reg_q, mem_to_reg_d;
  logic [4:0] rd_q, rd_d, reg_wr_addr_q, reg_wr_addr_d;
  logic [5:0] cnt_q, cnt_d;
  logic       reg_write_q, reg_write_d, mdr_load_q, mdr_load_d;
  logic       busy_q, busy_d, wb_done_q, wb_done_d, wb_err_q, wb_err_d, work;
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (wb_req) begin
        src_d   = wb_src;
        rd_d    = wb_rd;
        cnt_d   = wb_src == 4'd1 ? 6'(MEM_LAT - 1) : 6'd0;
        state_d = wb_src == 4'd1 ? MEM_WAIT :
                  wb_src inside {4'd3, 4'd4} ? MD_WAIT :
                  wb_src inside {4'd0, 4'd2, 4'd5, 4'd6, 4'd8} ? WRITE : ERROR;
      end
      MEM_WAIT: begin
        state_d = cnt_q == 6'd0 ? WRITE : MEM_WAIT;
        cnt_d   = cnt_q == 6'd0 ? 6'd0 : cnt_q - 6'd1;
      end
      MD_WAIT: begin
        state_d = md_done ? WRITE : cnt_q == 6'(MD_TIMEOUT - 1) ? ERROR : MD_WAIT;
        cnt_d   = cnt_q + 6'd1;
      end
      WRITE:   state_d = FINISH;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so each one lines up with its state
    work          = state_d inside {MEM_WAIT, MD_WAIT, WRITE, FINISH};
    mem_to_reg_d  = work ? src_d : 4'd0;
    reg_wr_addr_d = work ? rd_d : 5'd0;
    reg_write_d   = state_d == WRITE && rd_d != 5'd0;
    mdr_load_d    = state_d == MEM_WAIT && cnt_d == 6'd0;
    busy_d        = state_d != IDLE;
    wb_done_d     = state_d == FINISH;
    wb_err_d      = state_d == ERROR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      src_q         <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      mem_to_reg_q  <= '0;
      reg_wr_addr_q <= '0;
      reg_write_q   <= 1'b0;
      mdr_load_q    <= 1'b0;
      busy_q        <= 1'b0;
      wb_done_q     <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_write_q   <= reg_write_d;
      mdr_load_q    <= mdr_load_d;
      busy_q        <= busy_d;
      wb_done_q     <= wb_done_d;
      wb_err_q      <= wb_err_d;
    end
  end
  assign mem_to_reg  = mem_to_reg_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_write   = reg_write_q;
  assign mdr_load    = mdr_load_q;
  assign busy        = busy_q;
  assign wb_done     = wb_done_q;
  assign wb_err      = wb_err_q;
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed and randomized write-back transactions checked cycle by cycle against a latency model
module tb_wb_sequencer;
  localparam int MEM_LAT = 2;
  localparam int MD_TO   = 40;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wb_req = 1'b0;
  logic [3:0] wb_src = '0;
  logic [4:0] wb_rd = '0;
  logic       md_done = 1'b0;
  logic [3:0] mem_to_reg;
  logic       reg_write, mdr_load, busy, wb_done, wb_err;
  logic [4:0] reg_wr_addr;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic       rw;
    logic [3:0] m2r;
    logic [4:0] addr;
    logic       mdr, bsy, done, err;
  } exp_t;
  exp_t exp_q[$];
  bit   ac_q[$];
  wb_sequencer #(.MEM_LAT(MEM_LAT), .MD_TIMEOUT(MD_TO)) dut (
    .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_rd(wb_rd),
    .md_done(md_done), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_wr_addr(reg_wr_addr), .mdr_load(mdr_load), .busy(busy),
    .wb_done(wb_done), .wb_err(wb_err)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(logic rw, logic [3:0] m, logic [4:0] a, logic l, logic b, logic dn, logic er);
    mk = '{rw, m, a, l, b, dn, er};
  endfunction
  task automatic push(input exp_t e, input bit ac);
    exp_q.push_back(e);
    ac_q.push_back(ac);
  endtask
  // reg_wr_addr is only defined during the write/finish cycles and after reset
  task automatic check(input string tag, input int i, input exp_t e, input bit ac);
    exp_t obs;
    obs = '{reg_write, mem_to_reg, ac ? reg_wr_addr : e.addr, mdr_load, busy, wb_done, wb_err};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, i, obs, e);
    end
  endtask
  // expected per-cycle outputs after acceptance, from the latency rules; d = md_done rise index or -1
  task automatic plan(input logic [3:0] s, input logic [4:0] r, input int d);
    bit legal, md, timeout;
    exp_q.delete();
    ac_q.delete();
    legal   = s inside {0, 1, 2, 3, 4, 5, 6, 8};
    md      = s == 3 || s == 4;
    timeout = md && !(d >= 0 && d < MD_TO);
    if (s == 1)
      for (int i = 0; i < MEM_LAT; i++) push(mk(0, s, 0, i == MEM_LAT - 1, 1, 0, 0), 0);
    if (md)
      for (int i = 0; i < (timeout ? MD_TO : d + 1); i++) push(mk(0, s, 0, 0, 1, 0, 0), 0);
    if (!legal || timeout) push(mk(0, 0, 0, 0, 1, 0, 1), 0);
    else begin
      push(mk(r != 0, s, r, 0, 1, 0, 0), 1);
      push(mk(0, s, r, 0, 1, 1, 0), 1);
    end
    push(mk(0, 0, 0, 0, 0, 0, 0), 0);
  endtask
  task automatic run(input string tag, input logic [3:0] s, input logic [4:0] r, input int d, input bit scramble);
    wb_req = 1'b1;
    wb_src = s;
    wb_rd  = r;
    @(posedge clk); #1;
    wb_req = 1'b0;
    plan(s, r, d);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (d >= 0 && i == d) md_done = 1'b1;
      check(tag, i, exp_q[i], ac_q[i]);
      if (scramble) begin
        wb_src = 4'($urandom);
        wb_rd  = 5'($urandom);
        wb_req = i < exp_q.size() - 1 ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
    end
    md_done = 1'b0;
  endtask
  initial begin
    logic [3:0] s;
    logic [4:0] r;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, mk(0, 0, 0, 0, 0, 0, 0), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle", 0, mk(0, 0, 0, 0, 0, 0, 0), 1);
    run("alu_rd8", 0, 8, -1, 0);
    run("load_rd9", 1, 9, -1, 0);
    run("lo_md5", 4, 10, 5, 0);
    run("lo_timeout", 4, 10, -1, 0);
    run("hi_md_last", 3, 11, MD_TO - 1, 0);
    run("hi_md_first", 3, 12, 0, 0);
    run("illegal7", 7, 5, -1, 0);
    run("illegal12", 12, 5, -1, 0);
    run("const_rd0", 2, 0, -1, 0);
    wb_req = 1'b1;
    wb_src = 4'd1;
    wb_rd  = 5'd9;
    @(posedge clk); #1;
    wb_req = 1'b0;
    check("abort_memwait", 0, mk(0, 1, 9, 0, 1, 0, 0), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_reset", 0, mk(0, 0, 0, 0, 0, 0, 0), 1);
    @(posedge clk); #1;
    check("abort_after", 0, mk(0, 0, 0, 0, 0, 0, 0), 1);
    run("after_reset_lui", 8, 17, -1, 0);
    r      = 5'd21;
    wb_req = 1'b1;
    wb_src = 4'd6;
    wb_rd  = r;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      case (k % 3)
        0: check("b2b_write", k, mk(1, 6, r, 0, 1, 0, 0), 1);
        1: check("b2b_finish", k, mk(0, 6, r, 0, 1, 1, 0), 1);
        default: check("b2b_idle", k, mk(0, 0, 0, 0, 0, 0, 0), 0);
      endcase
      wb_src = k % 3 == 0 ? 4'($urandom) : 4'd6;
      wb_rd  = k % 3 == 0 ? 5'($urandom) : r;
      wb_req = k != 8;
      @(posedge clk); #1;
    end
    for (int n = 0; n < 30; n++) begin
      s = 4'($urandom_range(0, 15));
      r = 5'($urandom);
      run("random", s, r, (s == 3 || s == 4) ? int'($urandom_range(0, 12)) : -1, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
